// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 master for 16-bit {rw, addr, data} frames
// CIPO passes a 2-flop synchroniser and is captured on every SCLK rising transition.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       nCS,
  output logic       sclk,
  output logic       COPI,
  input  logic       CIPO,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [14:0] shift_q, shift_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  rd_q, rd_d;
  logic        cipo_meta_q, cipo_sync_q;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cnt_end;

  assign cnt_end = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    rd_d    = rd_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = S_SETUP;
          shift_d = {req_addr, req_data};
          copi_d  = req_rw;
          ncs_d   = 1'b0;
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
        end
      end
      S_SETUP: begin
        if (cnt_end) begin
          state_d = S_SHIFT;
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          cap_d   = {cap_q[6:0], cipo_sync_q};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (!cnt_end) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (sclk_q) begin
            // Falling edge: present the next bit; zeros trail the last one.
            sclk_d  = 1'b0;
            copi_d  = shift_q[14];
            shift_d = {shift_q[13:0], 1'b0};
          end else if (bit_q == 5'd15) begin
            state_d = S_HOLD;
            copi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
            cap_d  = {cap_q[6:0], cipo_sync_q};
          end
        end
      end
      S_HOLD: begin
        if (cnt_end) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          rd_d    = cap_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 5'd0;
      shift_q     <= 15'd0;
      cap_q       <= 8'd0;
      rd_q        <= 8'd0;
      cipo_meta_q <= 1'b0;
      cipo_sync_q <= 1'b0;
      ncs_q       <= 1'b1;
      sclk_q      <= 1'b0;
      copi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      rd_q        <= rd_d;
      cipo_meta_q <= CIPO;
      cipo_sync_q <= cipo_meta_q;
      ncs_q       <= ncs_d;
      sclk_q      <= sclk_d;
      copi_q      <= copi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign nCS       = ncs_q;
  assign sclk      = sclk_q;
  assign COPI      = copi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized scoreboard bench for spi_controller
// Two instances (CLK_DIV=4/CS_GAP=4 and CLK_DIV=2/CS_GAP=1) share stimulus; sel picks one.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int DIV_A = 4;
  localparam int GAP_A = 4;
  localparam int DIV_B = 2;
  localparam int GAP_B = 1;

  typedef struct {
    logic [15:0] bits;
    logic [7:0]  rd;
    int          gap;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       sel = 1'b0;
  logic       loopback = 1'b0;
  logic       abort = 1'b0;

  logic       ready_a, ncs_a, sclk_a, copi_a, cipo_a, busy_a, done_a;
  logic       ready_b, ncs_b, sclk_b, copi_b, busy_b, done_b;
  logic [7:0] rd_a, rd_b;

  logic       m_ready, m_ncs, m_sclk, m_copi, m_busy, m_done;
  logic [7:0] m_rd;
  int         div;

  item_t       sb[$];
  logic [15:0] pat_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(ready_a),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .nCS(ncs_a), .sclk(sclk_a), .COPI(copi_a), .CIPO(cipo_a),
    .busy(busy_a), .done(done_a), .rd_data(rd_a)
  );

  spi_controller #(.CLK_DIV(DIV_B), .CS_GAP(GAP_B)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(ready_b),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .nCS(ncs_b), .sclk(sclk_b), .COPI(copi_b), .CIPO(1'b1),
    .busy(busy_b), .done(done_b), .rd_data(rd_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_ncs   = sel ? ncs_b   : ncs_a;
  assign m_sclk  = sel ? sclk_b  : sclk_a;
  assign m_copi  = sel ? copi_b  : copi_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_rd    = sel ? rd_b    : rd_a;
  assign div     = sel ? DIV_B   : DIV_A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Peripheral model for instance A: shifts a random pattern out MSB first,
  // presenting the next bit after each falling SCLK it observes.
  logic [15:0] p_pat = 16'd0;
  logic        p_bit = 1'b0;
  int          p_idx = -1;
  logic        p_prev_ncs = 1'b1;
  logic        p_prev_sclk = 1'b0;

  assign cipo_a = loopback ? copi_a : p_bit;

  always @(negedge clk) begin
    if (!ncs_a && p_prev_ncs) begin
      p_pat = (pat_q.size() > 0) ? pat_q.pop_front() : 16'd0;
      p_bit = p_pat[15];
      p_idx = 14;
    end else if (!ncs_a && !sclk_a && p_prev_sclk && p_idx >= 0) begin
      p_bit = p_pat[p_idx];
      p_idx--;
    end
    p_prev_ncs  = ncs_a;
    p_prev_sclk = sclk_a;
  end

  // Monitor: rebuilds each frame from the pins and checks it against the scoreboard.
  int          cyc = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          mon_rise = 0;
  int          last_rise = -1;
  int          per_bad = 0;
  int          rdy_bad = 0;
  logic [15:0] bits = 16'd0;
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  item_t       it;

  always @(negedge clk) begin
    cyc++;
    if (!m_ncs) begin
      if (prev_ncs) begin
        low_cnt = 0; mon_rise = 0; bits = 16'd0; per_bad = 0; rdy_bad = 0; last_rise = -1;
        if (sb.size() == 0) fail("unexpected_frame");
        else if (sb[0].gap >= 0) check("ncs_high_gap", 32'(high_cnt), 32'(sb[0].gap));
      end
      low_cnt++;
      if (m_ready) rdy_bad++;
      if (m_sclk && !prev_sclk) begin
        bits = {bits[14:0], m_copi};
        mon_rise++;
        if (last_rise >= 0 && (cyc - last_rise) != 2 * div) per_bad++;
        last_rise = cyc;
      end
    end else begin
      if (!prev_ncs) begin
        high_cnt = 0;
        if (m_done) begin
          if (sb.size() == 0) begin
            fail("done_without_request");
          end else begin
            it = sb.pop_front();
            check("frame_bits", 32'(bits), 32'(it.bits));
            check("ncs_low_cycles", 32'(low_cnt), 32'(34 * div));
            check("sclk_rises", 32'(mon_rise), 32'd16);
            check("sclk_period_errors", 32'(per_bad), 32'd0);
            check("ready_during_frame", 32'(rdy_bad), 32'd0);
            check("rd_data", 32'(m_rd), 32'(it.rd));
          end
        end else if (abort) begin
          if (sb.size() > 0) it = sb.pop_front();
          abort = 1'b0;
        end else begin
          fail("ncs_rose_without_done");
        end
      end else if (m_done) begin
        fail("stray_done");
      end
      high_cnt++;
    end
    prev_ncs  = m_ncs;
    prev_sclk = m_sclk;
  end

  task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data, input int gap);
    item_t       ni;
    logic [15:0] pat;
    int          n;
    pat     = 16'($urandom);
    ni.bits = {rw, addr, data};
    ni.rd   = sel ? 8'hFF : (loopback ? data : pat[7:0]);
    ni.gap  = gap;
    sb.push_back(ni);
    if (!sel) pat_q.push_back(pat);
    @(negedge clk);
    req_rw = rw; req_addr = addr; req_data = data; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("accept_timeout");
    @(negedge clk);
    // Scramble inputs: the frame in flight must not follow them.
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = 7'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail("idle_timeout");
  endtask

  task automatic random_frames(input int count, input int gap_b2b);
    int g;
    g = -1;
    for (int i = 0; i < count; i++) begin
      send(1'($urandom), 7'($urandom), 8'($urandom), g);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        g = -1;
      end else begin
        g = gap_b2b;
      end
    end
    wait_idle();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    #2 rst_n = 1'b0;
    #1;
    check("rst_ncs", 32'(m_ncs), 32'd1);
    check("rst_sclk", 32'(m_sclk), 32'd0);
    check("rst_copi", 32'(m_copi), 32'd0);
    check("rst_rd_data", 32'(m_rd), 32'd0);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", 32'(m_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(m_ready), 32'd1);

    send(1'b1, 7'h00, 8'hA5, -1);
    wait_idle();

    send(1'b1, 7'h02, 8'h3C, -1);
    send(1'b1, 7'h04, 8'hFF, GAP_A + 1);
    wait_idle();

    loopback = 1'b1;
    send(1'b1, 7'($urandom), 8'h5A, -1);
    wait_idle();
    loopback = 1'b0;

    random_frames(8, GAP_A + 1);

    send(1'b1, 7'h11, 8'hC3, -1);
    @(negedge clk);
    n = 0;
    while (mon_rise < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("abort_wait_timeout");
    #2 abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_ncs", 32'(m_ncs), 32'd1);
    check("abort_sclk", 32'(m_sclk), 32'd0);
    check("abort_done", 32'(m_done), 32'd0);
    check("abort_rd_data", 32'(m_rd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_frame_dropped", 32'(sb.size()), 32'd0);
    send(1'b0, 7'h22, 8'h69, -1);
    wait_idle();

    sel = 1'b1;
    @(negedge clk);
    send(1'b1, 7'h01, 8'h01, -1);
    wait_idle();
    random_frames(4, GAP_B + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    fail("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 controller that drives the same 16-bit register-write frames our SPI peripheral receives. A frame is {rw, addr[6:0], data[7:0]}, sent MSB first. The block takes one request per valid/ready handshake, then generates nCS, SCLK and COPI from the system clock. It captures CIPO into rd_data. It sits in the test/bring-up fabric and in any tile that configures a peer tile over SPI.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255 (2 is the minimum for the peripheral's 2-flop synchronisers).
CS_GAP, 4, minimum clk cycles nCS stays high between frames; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request (high only in IDLE).
req_rw  input  1  frame bit 15 (1 = write).
req_addr  input  7  frame bits 14:8.
req_data  input  8  frame bits 7:0.
nCS  output  1  chip select, active low.
sclk  output  1  SPI clock, idle low.
COPI  output  1  serial data to peripheral.
CIPO  input  1  serial data from peripheral; synchronised internally with 2 flops.
busy  output  1  high from acceptance until GAP completes.
done  output  1  one-cycle pulse in the cycle nCS returns high.
rd_data  output  8  last 8 bits sampled on CIPO; updated at done.

Behaviour:
- Reset is asynchronous. Outputs during and after reset: nCS=1, sclk=0, COPI=0, busy=0, done=0, req_ready=0, rd_data=0x00.
- req_ready rises in the first clk after rst_n deasserts. All outputs are registered and glitch-free.
- Acceptance happens when req_valid && req_ready are high at a clk edge (cycle T).
  - shift_reg <= {rw, addr, data}.
  - Next state is SETUP; req_ready=0 and busy=1 from T+1.
- States:
  - IDLE: nCS=1, sclk=0, COPI=0, req_ready=1.
  - SETUP: from T+1, nCS=0, sclk=0, COPI=bit15. Lasts CLK_DIV cycles.
  - SHIFT: 16 bits. Each bit is CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0.
    - COPI advances to the next bit in the same cycle sclk falls, so it is stable across each rising edge.
    - The CIPO (synchronised) sample is shifted into the capture register at each sclk rising transition.
    - After bit 0's low half, go to HOLD.
  - HOLD: nCS=0, sclk=0, COPI=0 for CLK_DIV cycles, then go to GAP.
  - GAP: on entry nCS=1 and done=1 for that cycle, and rd_data <= capture[7:0]. Hold nCS high for CS_GAP cycles, then go to IDLE.
- Frame timing: nCS is low for exactly 34*CLK_DIV cycles. There are exactly 16 sclk rising edges per frame. SCLK period is 2*CLK_DIV.
- Back-to-back requests: minimum spacing from nCS rise to the next nCS fall is CS_GAP+1 cycles (GAP, then one IDLE cycle for acceptance).
- req_valid while not ready: the request is ignored and must be held by the requester. Inputs are sampled only at acceptance; later changes to req_* have no effect on the frame in flight.
- Reset mid-frame: immediate return to IDLE outputs. There is no done pulse and rd_data is cleared. A partial frame is discarded by the peripheral because nCS rises with fewer than 16 bits.
- Counters:
  - Half-period counter is 8 bits and wraps to 0 at CLK_DIV-1.
  - Bit counter is 5 bits, counts 0..15 and never wraps inside a frame.

Test Plan:
- Reset: assert rst_n=0 mid-idle. Required: nCS=1, sclk=0, COPI=0, rd_data=0x00. req_ready=1 one cycle after release.
- Single write, CLK_DIV=4: rw=1, addr=0x00, data=0xA5. Required: COPI samples at 16 rising edges = 0x80A5. nCS low for exactly 136 cycles. done pulses once, coincident with nCS rise.
- Back-to-back: req_valid held with (1,0x02,0x3C) then (1,0x04,0xFF). Required: req_ready low throughout frame 1. nCS high for exactly CS_GAP+1=5 cycles between frames. Second frame bits = 0x84FF.
- Loopback: CIPO tied to COPI with data=0x5A. Required: rd_data=0x5A at done.
- Reset mid-frame: pulse rst_n low after 7 rising sclk edges. Required: nCS=1 and sclk=0 asynchronously, no done pulse. A following request completes normally.
- Minimum divider, CLK_DIV=2, CS_GAP=1: frame 0x8101. Required: nCS low 68 cycles, sclk period 4 cycles, correct bits.
